window_avg_stage: RTL and testbench

WINDOW_AVG_STAGE -- requirements
Module: window_avg_stage

---
 rtl/opo_lock_pkg.sv | 17 +
 rtl/ring_avg.sv | 59 +++++
 rtl/window_avg_stage.sv | 114 +++++++++++
 tb/tb_window_avg_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/opo_lock_pkg.sv
// opo_lock_pkg: shared default widths and saturation limits for the window averaging path
package opo_lock_pkg;
    localparam int SUM_BITS_DEF = 32;
    localparam int OUT_BITS_DEF = 16;
    localparam int AVG_LOG2_DEF = 2;

    function automatic logic signed [63:0] sat_max(input int ob);
        return (64'sd1 <<< (ob - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int ob);
        return -(64'sd1 <<< (ob - 1));
    endfunction

    localparam logic signed [63:0] SAT_MAX_DEF = sat_max(OUT_BITS_DEF);
    localparam logic signed [63:0] SAT_MIN_DEF = sat_min(OUT_BITS_DEF);
endpackage

// File: rtl/ring_avg.sv
// ring_avg: D-entry ring of normalized sums with a running total and a primed flag
module ring_avg
    import opo_lock_pkg::*;
#(
    parameter int OUT_BITS = OUT_BITS_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic signed [OUT_BITS-1:0] wr_data,
    output logic signed [OUT_BITS-1:0] mean,
    output logic                       mean_vld,
    output logic                       primed
);
    localparam int D  = 1 << AVG_LOG2;
    localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int AW = OUT_BITS + AVG_LOG2;

    logic signed [OUT_BITS-1:0] ring_q [D];
    logic signed [OUT_BITS-1:0] ring_d [D];
    logic [PW-1:0]              ptr_q, ptr_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic                       vld_q, vld_d;
    logic                       primed_q, primed_d;
    logic                       last;

    assign last = ptr_q == PW'(D - 1);

    always_comb begin
        ring_d   = ring_q;
        vld_d    = wr_en;
        ptr_d    = wr_en ? (last ? '0 : ptr_q + 1'b1) : ptr_q;
        acc_d    = wr_en ? acc_q + AW'(wr_data) - AW'(ring_q[ptr_q]) : acc_q;
        primed_d = primed_q | (wr_en & last);
        if (wr_en) ring_d[ptr_q] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q   <= '{default: '0};
            ptr_q    <= '0;
            acc_q    <= '0;
            vld_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            ptr_q    <= ptr_d;
            acc_q    <= acc_d;
            vld_q    <= vld_d;
            primed_q <= primed_d;
        end
    end

    // dividing by D is a plain slice of the running total (arithmetic shift)
    assign mean     = acc_q[AW-1:AVG_LOG2];
    assign mean_vld = vld_q;
    assign primed   = primed_q;
endmodule

// File: rtl/window_avg_stage.sv
// window_avg_stage: captures window sums on cnt_timer edges, normalizes, saturates,
// averages over the last D windows and presents the result with a valid/ready handshake
module window_avg_stage
    import opo_lock_pkg::*;
#(
    parameter int SUM_BITS = SUM_BITS_DEF,
    parameter int OUT_BITS = OUT_BITS_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SUM_BITS-1:0] sum_in,
    input  logic                cnt_timer,
    input  logic [4:0]          shift_sel,
    input  logic                avg_ready,
    input  logic                clr_ovf,
    output logic [OUT_BITS-1:0] avg_out,
    output logic                avg_valid,
    output logic                primed,
    output logic                ovf,
    output logic                sat
);
    localparam logic signed [63:0] SAT_MAX = sat_max(OUT_BITS);
    localparam logic signed [63:0] SAT_MIN = sat_min(OUT_BITS);

    logic                       t1_q, t1_d, t2_q, t2_d, armed_q, armed_d;
    logic                       cap_vld_q, cap_vld_d;
    logic signed [SUM_BITS-1:0] cap_q, cap_d;
    logic [4:0]                 sh_q, sh_d;
    logic                       norm_vld_q, norm_vld_d;
    logic signed [OUT_BITS-1:0] norm_q, norm_d;
    logic signed [OUT_BITS-1:0] avg_q, avg_d;
    logic                       avg_valid_q, avg_valid_d;
    logic                       ovf_q, ovf_d, sat_q, sat_d;
    logic signed [SUM_BITS-1:0] shifted;
    logic signed [63:0]         sh_ext;
    logic signed [OUT_BITS-1:0] mean;
    logic                       mean_vld, ring_primed;
    logic                       clip_hi, clip_lo, strobe, load;

    assign shifted = cap_q >>> sh_q;
    assign sh_ext  = shifted;
    assign clip_hi = sh_ext > SAT_MAX;
    assign clip_lo = sh_ext < SAT_MIN;
    // armed blocks a level that is already high at reset release from looking like an edge
    assign strobe  = t1_q & ~t2_q & armed_q & ~(cap_vld_q | norm_vld_q | mean_vld);
    assign load    = mean_vld & ring_primed;

    always_comb begin
        t1_d        = cnt_timer;
        t2_d        = t1_q;
        armed_d     = armed_q | ~cnt_timer;
        cap_vld_d   = strobe;
        cap_d       = strobe ? $signed(sum_in) : cap_q;
        sh_d        = strobe ? shift_sel : sh_q;
        norm_vld_d  = cap_vld_q;
        norm_d      = !cap_vld_q ? norm_q :
                      clip_hi    ? SAT_MAX[OUT_BITS-1:0] :
                      clip_lo    ? SAT_MIN[OUT_BITS-1:0] : sh_ext[OUT_BITS-1:0];
        avg_d       = load ? mean : avg_q;
        avg_valid_d = load | (avg_valid_q & ~avg_ready);
        ovf_d       = (load & avg_valid_q & ~avg_ready) | (ovf_q & ~clr_ovf);
        sat_d       = (cap_vld_q & (clip_hi | clip_lo)) | (sat_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t1_q        <= 1'b0;
            t2_q        <= 1'b0;
            armed_q     <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_q       <= '0;
            sh_q        <= '0;
            norm_vld_q  <= 1'b0;
            norm_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            armed_q     <= armed_d;
            cap_vld_q   <= cap_vld_d;
            cap_q       <= cap_d;
            sh_q        <= sh_d;
            norm_vld_q  <= norm_vld_d;
            norm_q      <= norm_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            ovf_q       <= ovf_d;
            sat_q       <= sat_d;
        end
    end

    ring_avg #(
        .OUT_BITS(OUT_BITS),
        .AVG_LOG2(AVG_LOG2)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (norm_vld_q),
        .wr_data (norm_q),
        .mean    (mean),
        .mean_vld(mean_vld),
        .primed  (ring_primed)
    );

    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;
    assign primed    = ring_primed;
    assign ovf       = ovf_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_window_avg_stage.sv
// tb_window_avg_stage: scoreboard bench with a reference moving-average model
module tb_window_avg_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sum_in = '0;
    logic        cnt_timer = 1'b0;
    logic [4:0]  shift_sel = '0;
    logic        avg_ready = 1'b1;
    logic        clr_ovf = 1'b0;
    logic [15:0] avg_out;
    logic        avg_valid, primed, ovf, sat;

    typedef struct {
        bit     valid;
        longint out;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    longint ring[4];
    int     ptr, cnt;
    longint m_out;
    bit     m_ovf, m_sat, v_prev;

    always #5 clk = ~clk;

    window_avg_stage dut (
        .clk      (clk),
        .rst      (rst),
        .sum_in   (sum_in),
        .cnt_timer(cnt_timer),
        .shift_sel(shift_sel),
        .avg_ready(avg_ready),
        .clr_ovf  (clr_ovf),
        .avg_out  (avg_out),
        .avg_valid(avg_valid),
        .primed   (primed),
        .ovf      (ovf),
        .sat      (sat)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (ring[i]) ring[i] = 0;
        ptr = 0; cnt = 0; m_out = 0; m_ovf = 0; m_sat = 0; v_prev = 0;
        sb.delete();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, ".primed"}, longint'(primed), longint'(cnt == 4));
        chk({tag, ".ovf"}, longint'(ovf), longint'(m_ovf));
        chk({tag, ".sat"}, longint'(sat), longint'(m_sat));
    endtask

    task automatic window(input longint s, input int sh, input bit rdy);
        longint n, tot;
        bit     ld, v;
        exp_t   e;
        @(posedge clk); #1;
        cnt_timer = 1'b1;
        sum_in    = s[31:0];
        shift_sel = 5'(sh);
        repeat (4) @(posedge clk);
        #1 avg_ready = rdy;
        n = s >>> sh;
        if (n > 32767) begin n = 32767; m_sat = 1; end
        else if (n < -32768) begin n = -32768; m_sat = 1; end
        ring[ptr] = n;
        ptr = (ptr + 1) % 4;
        if (cnt < 4) cnt++;
        ld = cnt == 4;
        if (ld) begin
            tot = ring[0] + ring[1] + ring[2] + ring[3];
            m_out = tot >>> 2;
            if (v_prev && !rdy) m_ovf = 1;
        end
        v = ld | (v_prev & !rdy);
        e.valid = v;
        e.out   = m_out;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("win.avg_valid", longint'(avg_valid), longint'(e.valid));
        chk("win.avg_out", longint'($signed(avg_out)), e.out);
        check_flags("win");
        v_prev = rdy ? 1'b0 : v;
        cnt_timer = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        m_ovf = 0; m_sat = 0;
        @(negedge clk);
        chk("clr.ovf", longint'(ovf), 0);
        chk("clr.sat", longint'(sat), 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".avg_valid"}, longint'(avg_valid), 0);
        chk({tag, ".avg_out"}, longint'(avg_out), 0);
        chk({tag, ".primed"}, longint'(primed), 0);
        chk({tag, ".ovf"}, longint'(ovf), 0);
        chk({tag, ".sat"}, longint'(sat), 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks("reset");
        repeat (4) window(400, 2, 1'b1);
        window(-800, 0, 1'b1);
        window(800, 0, 1'b1);
        window(-800, 0, 1'b1);
        window(800, 0, 1'b1);
        window(1000, 0, 1'b0);
        window(2000, 0, 1'b0);
        pulse_clr();
        window(3000, 0, 1'b1);
        repeat (4) window(64'sd2147483647, 0, 1'b1);
        repeat (4) window(-64'sd2147483648, 0, 1'b1);
        pulse_clr();
        @(posedge clk); #1;
        cnt_timer = 1'b1;
        sum_in    = 32'd400;
        shift_sel = 5'd2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
        reset_checks("midrst");
        cnt_timer = 1'b0;
        repeat (4) window(400, 2, 1'b1);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
